// File: rtl/rs_dec_syndrome_gen.sv
// rs_dec_syndrome_gen: Horner-form GF(256) syndrome accumulator with per-codeword capture.
module rs_dec_syndrome_gen #(
    parameter int N    = 32,
    parameter int NSYM = 4,
    parameter int FCR  = 0
) (
    input  logic              i_clk,
    input  logic              i_res,
    input  logic              i_frame_sync,
    input  logic [7:0]        i_data,
    input  logic              i_data_valid,
    output logic [8*NSYM-1:0] o_syn,
    output logic              o_valid,
    output logic              o_nonzero,
    output logic              o_frame_err,
    output logic [7:0]        o_count
);
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1D : 8'h00);
    endfunction

    function automatic logic [7:0] gf_pow(input int e);
        logic [7:0] p;
        p = 8'h01;
        for (int k = 0; k < e; k++) p = xt(p);
        return p;
    endfunction

    // c is an elaboration-time constant, so this folds into a fixed XOR matrix
    function automatic logic [7:0] mulc(input logic [7:0] x, input logic [7:0] c);
        logic [7:0] r, p;
        r = '0;
        p = c;
        for (int b = 0; b < 8; b++) begin
            r = r ^ (x[b] ? p : 8'h00);
            p = xt(p);
        end
        return r;
    endfunction

    logic [8*NSYM-1:0] acc, nxt;
    logic [7:0]        cnt;

    genvar j;
    for (j = 0; j < NSYM; j++) begin : g_syn
        localparam logic [7:0] C = gf_pow((FCR + j) % 255);
        assign nxt[8*j +: 8] = mulc(acc[8*j +: 8], C) ^ i_data;
    end

    assign o_count = cnt;

    always_ff @(posedge i_clk) begin
        if (i_res) begin
            acc         <= '0;
            cnt         <= '0;
            o_syn       <= '0;
            o_valid     <= 1'b0;
            o_nonzero   <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            if (i_frame_sync) begin
                o_frame_err <= cnt != 8'd0;
                acc         <= i_data_valid ? {NSYM{i_data}} : '0;
                cnt         <= i_data_valid ? 8'd1 : 8'd0;
            end else if (i_data_valid) begin
                if (cnt == 8'(N - 1)) begin
                    o_syn     <= nxt;
                    o_nonzero <= |nxt;
                    o_valid   <= 1'b1;
                    acc       <= '0;
                    cnt       <= '0;
                end else begin
                    acc <= nxt;
                    cnt <= cnt + 8'd1;
                end
            end
        end
    end
endmodule
